// File: rtl/input_conditioner_pkg.sv
// Shared constants, repeat-FSM state type and counter sizing helper for the
// input conditioner front end.
package input_cond_pkg;

    localparam int unsigned BTN_TOP = 0;
    localparam int unsigned BTN_BOT = 1;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        REPEAT
    } rpt_state_t;

    // Bits needed to hold 0..term; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned term);
        return (term == 0) ? 1 : $clog2(term + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Button/tick bundle between the board-facing stimulus and the conditioner.
interface input_conditioner_if;

    logic [1:0] btn;
    logic       tick_clr;
    logic       tick;
    logic [1:0] btn_lvl;
    logic [1:0] btn_press;
    logic       run;

    modport master (
        output btn,
        output tick_clr,
        input  tick,
        input  btn_lvl,
        input  btn_press,
        input  run
    );

    modport slave (
        input  btn,
        input  tick_clr,
        output tick,
        output btn_lvl,
        output btn_press,
        output run
    );

endinterface

// File: rtl/input_conditioner_debounce.sv
// One button: two-flop synchronizer, debounce filter, press edge detect and
// hold/auto-repeat state machine.
module btn_debounce
    import input_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic lvl,
    output logic press,
    output logic first_press
);

    localparam int unsigned DEB_W     = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam int unsigned HOLD_TERM = (HOLD_CYCLES > REPEAT_CYCLES) ?
                                        HOLD_CYCLES - 1 : REPEAT_CYCLES - 1;
    localparam int unsigned HOLD_W    = cnt_width(HOLD_TERM);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

    logic              sync1;
    logic              sync2;
    logic              pressed_s;
    logic              stable;
    logic [DEB_W-1:0]  db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    rpt_state_t        state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    assign pressed_s = ~sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (pressed_s == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DEB_LAST) begin
            stable <= pressed_s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // IDLE only ever sees stable=1 on the first cycle after a rise, so the
    // state register doubles as the registered edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            press       <= 1'b0;
            first_press <= 1'b0;
        end else begin
            press       <= 1'b0;
            first_press <= 1'b0;
            case (state)
                IDLE: begin
                    if (stable) begin
                        state       <= PRESSED;
                        hold_cnt    <= HOLD_W'(1);
                        press       <= 1'b1;
                        first_press <= 1'b1;
                    end
                end
                PRESSED: begin
                    if (!stable) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state    <= REPEAT;
                        hold_cnt <= '0;
                        press    <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!stable) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end else if (hold_cnt == REP_LAST) begin
                        hold_cnt <= '0;
                        press    <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    assign lvl = stable;

endmodule

// File: rtl/input_conditioner.sv
// Front end for the clock/stopwatch datapath: 1 Hz count enable, two
// conditioned buttons and the run/pause toggle.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50000000,
    parameter int unsigned TICK_HZ         = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input_conditioner_if.slave  bus
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned DIV_W = cnt_width(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       lvl;
    logic [1:0]       press;
    logic             first_top;
    logic             unused_first_bot;
    logic             run_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (bus.tick_clr || (div_cnt == DIV_LAST)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_btn_top (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_n       (bus.btn[BTN_TOP]),
        .lvl         (lvl[BTN_TOP]),
        .press       (press[BTN_TOP]),
        .first_press (first_top)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_btn_bot (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_n       (bus.btn[BTN_BOT]),
        .lvl         (lvl[BTN_BOT]),
        .press       (press[BTN_BOT]),
        .first_press (unused_first_bot)
    );

    // Repeat pulses must not toggle run, hence first_press rather than press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else if (first_top) begin
            run_q <= ~run_q;
        end
    end

    always_comb begin
        bus.tick      = (div_cnt == DIV_LAST) && !bus.tick_clr;
        bus.btn_lvl   = lvl;
        bus.btn_press = press;
        bus.run       = run_q;
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed and randomized checks of input_conditioner against a window-based
// behavioural model of tick, debounce, press/repeat and run.
module tb_input_conditioner;

    localparam int unsigned DIV  = 10;
    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 20;
    localparam int unsigned REP  = 5;
    localparam int unsigned HLEN = DEB + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    input_conditioner_if bus();

    input_conditioner #(
        .CLK_HZ          (100),
        .TICK_HZ         (10),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int unsigned k;
    int unsigned p;
    int          rise [2];
    bit          hist [2][HLEN];
    logic [1:0]  lvl_m;
    logic [1:0]  press_m;
    logic        run_m;
    bit          first_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, k);
        end
    endtask

    task automatic model_reset();
        k = 0;
        p = 0;
        lvl_m = '0;
        press_m = '0;
        run_m = 1'b0;
        first_prev = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rise[i] = 0;
            for (int j = 0; j < HLEN; j++) hist[i][j] = 1'b0;
        end
    endtask

    // Level flips once the last DEB synchronized samples (raw delayed by 2)
    // all disagree with it; pulses at 1, HOLD, HOLD+n*REP edges after a rise.
    task automatic model_edge();
        bit first0;
        k++;
        if (bus.tick_clr) p = 0; else p++;
        first0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit old;
            bit all_diff;
            int d;
            for (int j = HLEN - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = ~bus.btn[1'(i)];
            old = lvl_m[1'(i)];
            d = int'(k) - rise[i];
            press_m[1'(i)] = old && ((d == 1) ||
                             (d >= int'(HOLD) && ((d - int'(HOLD)) % int'(REP)) == 0));
            if (i == 0) first0 = old && (d == 1);
            all_diff = 1'b1;
            for (int j = 2; j < HLEN; j++) if (hist[i][j] == old) all_diff = 1'b0;
            if (all_diff) begin
                lvl_m[1'(i)] = ~old;
                if (!old) rise[i] = int'(k);
            end
        end
        if (first_prev) run_m = ~run_m;
        first_prev = first0;
    endtask

    task automatic check_outputs();
        chk("tick", bus.tick, ((p % DIV) == DIV - 1) && !bus.tick_clr);
        chk("btn_lvl", bus.btn_lvl, lvl_m);
        chk("btn_press", bus.btn_press, press_m);
        chk("run", bus.run, run_m);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned c = 0; c < n; c++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tick"}, bus.tick, 0);
        chk({tag, "_lvl"}, bus.btn_lvl, 0);
        chk({tag, "_press"}, bus.btn_press, 0);
        chk({tag, "_run"}, bus.run, 0);
    endtask

    task automatic do_reset(input int unsigned cycles);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        for (int unsigned c = 0; c < cycles; c++) begin
            @(negedge clk);
            check_reset_outputs("rst_hold");
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int unsigned n;
        int unsigned len;
        bus.btn = 2'b11;
        bus.tick_clr = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset(3);

        // divider: free run, restart before cycle 25, then clear on DIV-1
        steps(24);
        bus.tick_clr = 1'b1;
        step();
        bus.tick_clr = 1'b0;
        steps(12);
        n = 0;
        while (((p % DIV) != DIV - 1) && n < 20) begin
            step();
            n++;
        end
        bus.tick_clr = 1'b1;
        #1;
        chk("tick_clr_wins", bus.tick, 0);
        step();
        bus.tick_clr = 1'b0;
        steps(3);

        // glitch shorter than the debounce window
        bus.btn[1] = 1'b0;
        steps(3);
        bus.btn[1] = 1'b1;
        steps(10);
        chk("glitch_lvl", bus.btn_lvl, 0);

        // long hold of the bottom button: latency then auto-repeat
        bus.btn[1] = 1'b0;
        n = 0;
        while (n < 20) begin
            step();
            n++;
            if (bus.btn_lvl[1]) break;
        end
        chk("lvl_latency", n, 6);
        steps(60 - n);
        bus.btn[1] = 1'b1;
        steps(15);

        // two short presses, then a long hold of the top button
        for (int r = 0; r < 2; r++) begin
            bus.btn[0] = 1'b0;
            steps(10);
            bus.btn[0] = 1'b1;
            steps(15);
        end
        chk("run_two_presses", bus.run, 0);
        bus.btn[0] = 1'b0;
        steps(60);
        bus.btn[0] = 1'b1;
        steps(15);
        chk("run_long_hold", bus.run, 1);

        // reset while repeating with the button still held
        bus.btn[0] = 1'b0;
        steps(40);
        do_reset(3);
        n = 0;
        while (n < 20) begin
            step();
            n++;
            if (bus.btn_press[0]) break;
        end
        chk("press_after_reset", n, 7);
        steps(3);
        chk("run_after_reset", bus.run, 1);
        bus.btn[0] = 1'b1;
        steps(15);

        // both buttons on the same cycle
        bus.btn = 2'b00;
        n = 0;
        while (n < 20) begin
            step();
            n++;
            if (bus.btn_press != 2'b00) break;
        end
        chk("both_press", bus.btn_press, 2'b11);
        steps(9);
        bus.btn = 2'b11;
        steps(15);
        chk("run_both", bus.run, 0);

        // random button segments, occasional clears and resets
        for (int s = 0; s < 60; s++) begin
            bus.btn = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 40);
            for (int unsigned c = 0; c < len; c++) begin
                bus.tick_clr = ($urandom_range(0, 15) == 0);
                step();
            end
            bus.tick_clr = 1'b0;
            if ($urandom_range(0, 19) == 0) do_reset(2);
        end
        bus.btn = 2'b11;
        steps(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage for the clock/stopwatch/timer datapath. It turns the raw board clock and the two raw push buttons into clean control events.
- Outputs:
  - a one-cycle 1 Hz count enable;
  - debounced button levels;
  - single-cycle press pulses, with auto-repeat while a button is held (used for time-set increments);
  - the run/pause toggle that the counter stage consumes.
- The counter stage becomes single-clock-domain with enables, instead of clocking off a button edge.

Parameters:
- CLK_HZ, 50000000, board clock frequency in Hz.
- TICK_HZ, 1, count-enable rate; DIV = CLK_HZ/TICK_HZ, must be an integer >= 2.
- DEBOUNCE_CYCLES, 1000000, cycles a new synchronized level must hold before it is accepted (20 ms).
- HOLD_CYCLES, 25000000, cycles a button must stay debounced-pressed before auto-repeat starts.
- REPEAT_CYCLES, 5000000, auto-repeat pulse period once repeating.

Ports:
- clk  in  1  board clock; all state on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- btn  in  2  raw buttons, active-low (0 = pressed); btn[0] = top, btn[1] = bottom.
- tick_clr  in  1  synchronous restart of the tick divider.
- tick  out  1  one-cycle pulse every DIV cycles.
- btn_lvl  out  2  debounced level, active-high (1 = pressed).
- btn_press  out  2  one-cycle pulse on debounced press edge, plus auto-repeat pulses.
- run  out  1  run/pause state; toggles on each btn_press[0] that is not a repeat.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - synchronizer flops are set to 1 (released);
  - debounce, hold and divider counters are cleared;
  - outputs: tick = 0, btn_lvl = 00, btn_press = 00, run = 0.
- Synchronizer:
  - two flops per button;
  - raw-to-debounce-input latency is 2 cycles.
- Debounce (per button, independent):
  - stable register starts at released;
  - while the synchronized value differs from stable, cnt increments;
  - if the value matches stable again before acceptance, cnt clears to 0 on that cycle;
  - when cnt == DEBOUNCE_CYCLES-1 and the value still differs, stable takes the new value and cnt clears;
  - net effect: a clean edge appears on btn_lvl DEBOUNCE_CYCLES+2 cycles after the raw edge;
  - glitches shorter than DEBOUNCE_CYCLES never reach btn_lvl.
- Press pulse:
  - btn_press[i] = 1 for exactly one cycle, on the cycle after btn_lvl[i] rises (registered edge detect);
  - releases produce no pulse.
- Auto-repeat (per button):
  - a hold counter runs while btn_lvl[i] = 1;
  - at HOLD_CYCLES-1 it emits a btn_press pulse, enters REPEAT, and reloads;
  - in REPEAT it emits a pulse every REPEAT_CYCLES;
  - release (btn_lvl = 0) returns to IDLE and clears the counter immediately;
  - per-button states: IDLE -> PRESSED (on rise) -> REPEAT (on hold expiry) -> IDLE (on release, from either state);
  - repeat pulses never coincide with the initial press pulse.
- Run toggle:
  - run flips only on the initial press pulse of button 0 (PRESSED entry);
  - repeat pulses do not flip run.
- Tick divider:
  - counter 0..DIV-1, starting at 0 after reset;
  - tick = 1 in the cycle the counter equals DIV-1, after which the counter wraps to 0;
  - first tick comes DIV cycles after reset release, then every DIV cycles.
  - tick_clr = 1: counter goes to 0 and tick is forced to 0 on that cycle, even if the counter is at DIV-1 (clear wins); next tick comes DIV cycles after the clear.
- Widths: each counter is sized with $clog2 of its terminal value; no counter ever exceeds its terminal value.
- Both buttons pressed together: fully independent. Both pulses may assert in the same cycle; the consumer resolves priority.
- Reset asserted mid-debounce or mid-repeat: all state is discarded. A button still held at reset release is debounced afresh and produces exactly one press pulse.

Decomposition:
- Package input_cond_pkg:
  - BTN_TOP = 0, BTN_BOT = 1 index constants;
  - repeat-FSM state enum (IDLE, PRESSED, REPEAT);
  - a function computing counter width from a terminal count.
- Sub-module btn_debounce (one instance per button): synchronizer, debounce, edge detect and repeat FSM.
  - Outputs: lvl, press, first_press.
- The top level holds the tick divider and the run flop only.

Test Plan:
All scenarios use scaled parameters: CLK_HZ = 100, TICK_HZ = 10 (DIV = 10), DEBOUNCE_CYCLES = 4, HOLD_CYCLES = 20, REPEAT_CYCLES = 5.
- Tick: release reset, idle 35 cycles -> tick high at cycles 10, 20, 30 after release, exactly 1 cycle each; tick_clr at cycle 25 -> next tick at cycle 35.
- Debounce: drive btn[1] low for 3 cycles then high -> btn_lvl stays 00 and no press. Drive it low and hold -> btn_lvl[1] rises 6 cycles after the edge, with a single btn_press[1] pulse the next cycle.
- Auto-repeat: hold btn[1] low for 60 cycles -> initial pulse, then pulses 20, 25, 30, 35 cycles after btn_lvl rose; release -> pulses stop and btn_lvl falls 6 cycles later.
- Run toggle: two separate short (10-cycle) presses of btn[0] -> run goes 0 -> 1 -> 0. A 60-cycle hold -> run flips once only, despite repeat pulses.
- Reset mid-hold: assert rst_n = 0 during REPEAT with btn[0] held, release with button still held -> all outputs 0 in reset; one fresh press pulse 7 cycles after release; run = 1.
- Simultaneous: both buttons pressed on the same cycle -> btn_press = 11 for one cycle; run toggles.
